bcast2: RTL and testbench

Splits one dti stream into two identical dti streams: each transfer accepted on `din` is delivered exactly once on `dout0` and exactly once on `dout1`. It is the fan-out counterpart of the two-input join comparators (`neq` and similar), which consume two streams into one. Per-branch acknowledge state lets the two consumers accept the same transfer in different cycles without duplicating or dropping data. It sits between a producer and two independent consumers, such as a comparator and a logger.

---
 rtl/bcast2.sv | 117 +++++++++++
 tb/tb_bcast2.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcast2.sv
// bcast2: fans one valid/ready stream out to two branches so that every accepted word is delivered once per branch.
// Optional macro BCAST2_DECOUPLE_EN builds per-branch FIFOs of DEPTH entries with registered outputs.
module bcast2 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_din_valid,
    input  logic [DATA_W-1:0] i_din_data,
    output logic              o_din_ready,
    output logic              o_dout0_valid,
    output logic [DATA_W-1:0] o_dout0_data,
    input  logic              i_dout0_ready,
    output logic              o_dout1_valid,
    output logic [DATA_W-1:0] o_dout1_data,
    input  logic              i_dout1_ready
);

    if (DEPTH < 2) begin : g_depth_chk
        $error("bcast2: DEPTH must be at least 2");
    end

    logic w_din_hs;

`ifdef BCAST2_DECOUPLE_EN

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]        w_out_ready;
    logic [1:0]        w_out_valid;
    logic [1:0]        w_full;
    logic [DATA_W-1:0] w_out_data [2];

    assign w_out_ready   = {i_dout1_ready, i_dout0_ready};
    // Ready depends only on registered occupancy, so no ready-to-ready path exists.
    assign o_din_ready   = ~(|w_full) & ~rst;
    assign w_din_hs      = i_din_valid & o_din_ready;
    assign o_dout0_valid = w_out_valid[0];
    assign o_dout0_data  = w_out_data[0];
    assign o_dout1_valid = w_out_valid[1];
    assign o_dout1_data  = w_out_data[1];

    for (genvar b = 0; b < 2; b++) begin : g_fifo
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wr_ptr;
        logic [PTR_W-1:0]  r_rd_ptr;
        logic [CNT_W-1:0]  r_count;
        logic              w_rd;

        assign w_full[b]      = (r_count == CNT_W'(DEPTH));
        assign w_out_valid[b] = (r_count != '0) & ~rst;
        assign w_out_data[b]  = r_mem[r_rd_ptr];
        assign w_rd           = w_out_valid[b] & w_out_ready[b];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_din_hs) begin
                    r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_rd) begin
                    r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                end
                case ({w_din_hs, w_rd})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage is data only and needs no reset; occupancy decides what is valid.
        always_ff @(posedge clk) begin
            if (w_din_hs) begin
                r_mem[r_wr_ptr] <= i_din_data;
            end
        end
    end

`else

    logic r_done0;
    logic r_done1;
    logic w_hs0;
    logic w_hs1;

    always_comb begin
        o_dout0_valid = i_din_valid & ~r_done0 & ~rst;
        o_dout1_valid = i_din_valid & ~r_done1 & ~rst;
        w_hs0         = o_dout0_valid & i_dout0_ready;
        w_hs1         = o_dout1_valid & i_dout1_ready;
        // Release the input in the cycle the last outstanding branch takes the word.
        o_din_ready   = (r_done0 | w_hs0) & (r_done1 | w_hs1) & ~rst;
        w_din_hs      = i_din_valid & o_din_ready;
    end

    assign o_dout0_data = i_din_data;
    assign o_dout1_data = i_din_data;

    always_ff @(posedge clk) begin
        if (rst || w_din_hs) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_done0 <= r_done0 | w_hs0;
            r_done1 <= r_done1 | w_hs1;
        end
    end

`endif

endmodule

// File: tb/tb_bcast2.sv
// Self-checking bench for bcast2: directed scenarios plus randomized traffic against a stream-level model.
module tb_bcast2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
`ifdef BCAST2_DECOUPLE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_din_valid;
    logic [DATA_W-1:0] i_din_data;
    logic              o_din_ready;
    logic              o_dout0_valid;
    logic [DATA_W-1:0] o_dout0_data;
    logic              i_dout0_ready;
    logic              o_dout1_valid;
    logic [DATA_W-1:0] o_dout1_data;
    logic              i_dout1_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] tx[$];
    logic [DATA_W-1:0] sent[$];
    logic [DATA_W-1:0] rx0[$];
    logic [DATA_W-1:0] rx1[$];
    int acc;
    int inv_viol;
    int first_in_cyc;
    int last_in_cyc;
    int first_out_cyc;

    bcast2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_din_valid  (i_din_valid),
        .i_din_data   (i_din_data),
        .o_din_ready  (o_din_ready),
        .o_dout0_valid(o_dout0_valid),
        .o_dout0_data (o_dout0_data),
        .i_dout0_ready(i_dout0_ready),
        .o_dout1_valid(o_dout1_valid),
        .o_dout1_data (o_dout1_data),
        .i_dout1_ready(i_dout1_ready)
    );

    always #5 clk = ~clk;

    // Streams words from tx through the DUT and records what each branch receives.
    // Model: each branch must see exactly the sent list; in zero-latency mode the input is
    // accepted exactly when both branches have the word, otherwise each branch lags by at most DEPTH.
    task automatic run(input int mode, input int max_cycles);
        int cyc = 0;
        int n0;
        int n1;
        logic took = 1'b0;
        sent = tx;
        rx0.delete();
        rx1.delete();
        acc = 0;
        inv_viol = 0;
        first_in_cyc = -1;
        last_in_cyc = -1;
        first_out_cyc = -1;
        i_din_valid = 1'b0;
        while (1) begin
            @(posedge clk);
            #1;
            case (mode)
                1: begin
                    i_dout0_ready = 1'($urandom_range(1));
                    i_dout1_ready = 1'($urandom_range(1));
                end
                2: begin
                    i_dout0_ready = (cyc % 2 == 0);
                    i_dout1_ready = (cyc % 2 == 1);
                end
                default: begin
                    i_dout0_ready = 1'b1;
                    i_dout1_ready = 1'b1;
                end
            endcase
            if (took) begin
                i_din_valid = 1'b0;
                took = 1'b0;
            end
            if (!i_din_valid && tx.size() > 0) begin
                if (mode != 1 || $urandom_range(3) != 0) begin
                    i_din_valid = 1'b1;
                    i_din_data  = tx[0];
                end
            end
            @(negedge clk);
            if (o_dout0_valid && i_dout0_ready) begin
                rx0.push_back(o_dout0_data);
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (LAT == 0 && o_dout0_data !== i_din_data) inv_viol++;
            end
            if (o_dout1_valid && i_dout1_ready) begin
                rx1.push_back(o_dout1_data);
                if (LAT == 0 && o_dout1_data !== i_din_data) inv_viol++;
            end
            if (i_din_valid && o_din_ready) begin
                acc++;
                void'(tx.pop_front());
                took = 1'b1;
                if (first_in_cyc < 0) first_in_cyc = cyc;
                last_in_cyc = cyc;
            end
            n0 = rx0.size();
            n1 = rx1.size();
            if (LAT == 0) begin
                if (acc != ((n0 < n1) ? n0 : n1) || n0 - n1 > 1 || n1 - n0 > 1) inv_viol++;
            end else begin
                if (n0 > acc || n1 > acc || acc - n0 > DEPTH || acc - n1 > DEPTH) inv_viol++;
            end
            cyc++;
            if (tx.size() == 0 && n0 == sent.size() && n1 == sent.size()) break;
            if (cyc >= max_cycles) begin
                inv_viol += 1000;
                break;
            end
        end
        @(posedge clk);
        #1;
        i_din_valid   = 1'b0;
        i_dout0_ready = 1'b0;
        i_dout1_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_din_valid = 1'b1;
        i_din_data = 8'h55;
        i_dout0_ready = 1'b1;
        i_dout1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (o_din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready got=%b exp=0", o_din_ready); end
        n_tests++;
        if (o_dout0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout0_valid got=%b exp=0", o_dout0_valid); end
        n_tests++;
        if (o_dout1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout1_valid got=%b exp=0", o_dout1_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_din_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_dout0_valid !== 1'b0) begin n_fail++; $display("FAIL idle_dout0_valid got=%b exp=0", o_dout0_valid); end
        n_tests++;
        if (o_dout1_valid !== 1'b0) begin n_fail++; $display("FAIL idle_dout1_valid got=%b exp=0", o_dout1_valid); end
        n_tests++;
        if (o_din_ready !== 1'(LAT)) begin n_fail++; $display("FAIL idle_din_ready got=%b exp=%0d", o_din_ready, LAT); end
    endtask

    task automatic test_broadcast();
        tx = '{8'h11, 8'h22, 8'h33};
        run(0, 50);
        n_tests++;
        if (rx0.size() !== 3 || rx1.size() !== 3) begin
            n_fail++;
            $display("FAIL bcast_count got=%0d/%0d exp=3/3", rx0.size(), rx1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (rx0[i] !== sent[i] || rx1[i] !== sent[i]) begin
                    n_fail++;
                    $display("FAIL bcast_word%0d got=%h/%h exp=%h", i, rx0[i], rx1[i], sent[i]);
                end
            end
        end
        n_tests++;
        if (first_out_cyc - first_in_cyc !== LAT) begin
            n_fail++;
            $display("FAIL bcast_latency got=%0d exp=%0d", first_out_cyc - first_in_cyc, LAT);
        end
        n_tests++;
        if (last_in_cyc - first_in_cyc !== 2) begin
            n_fail++;
            $display("FAIL bcast_throughput got=%0d exp=2", last_in_cyc - first_in_cyc);
        end
        n_tests++;
        if (inv_viol !== 0) begin n_fail++; $display("FAIL bcast_model got=%0d exp=0", inv_viol); end
    endtask

    task automatic test_stall();
        @(posedge clk);
        #1;
        i_din_valid = 1'b1;
        i_din_data = 8'hA5;
        i_dout0_ready = 1'b1;
        i_dout1_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_dout0_valid !== 1'b1 || o_dout0_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL stall_first_dout0 got=%b/%h exp=1/a5", o_dout0_valid, o_dout0_data);
        end
        n_tests++;
        if (o_din_ready !== 1'b0) begin n_fail++; $display("FAIL stall_din_ready0 got=%b exp=0", o_din_ready); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n_tests++;
            if (o_dout0_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dout0_dup%0d got=%b exp=0", i, o_dout0_valid); end
            n_tests++;
            if (o_din_ready !== 1'b0) begin n_fail++; $display("FAIL stall_din_ready%0d got=%b exp=0", i + 1, o_din_ready); end
            n_tests++;
            if (o_dout1_valid !== 1'b1) begin n_fail++; $display("FAIL stall_dout1_hold%0d got=%b exp=1", i, o_dout1_valid); end
        end
        @(posedge clk);
        #1;
        i_dout1_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_dout1_valid !== 1'b1 || o_dout1_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL stall_release_dout1 got=%b/%h exp=1/a5", o_dout1_valid, o_dout1_data);
        end
        n_tests++;
        if (o_din_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=1", o_din_ready); end
        @(posedge clk);
        #1;
        i_din_data = 8'h5A;
        @(negedge clk);
        n_tests++;
        if (o_dout0_valid !== 1'b1 || o_dout1_valid !== 1'b1 || o_din_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done_cleared got=%b%b%b exp=111", o_dout0_valid, o_dout1_valid, o_din_ready);
        end
        @(posedge clk);
        #1;
        i_din_valid = 1'b0;
        i_dout0_ready = 1'b0;
        i_dout1_ready = 1'b0;
    endtask

    task automatic test_depth();
        logic [DATA_W-1:0] d;
        i_dout0_ready = 1'b1;
        i_dout1_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) i_dout1_ready = 1'b1;
            i_din_valid = (c < 6);
            d = (c < 2) ? DATA_W'(c + 1) : 8'h03;
            i_din_data = d;
            @(negedge clk);
            n_tests++;
            if (c < 6 && o_din_ready !== 1'((c < 2) || (c == 5))) begin
                n_fail++;
                $display("FAIL depth_din_ready_c%0d got=%b", c, o_din_ready);
            end
            if (c == 1 || c == 2) begin
                n_tests++;
                if (o_dout0_valid !== 1'b1 || o_dout0_data !== DATA_W'(c)) begin
                    n_fail++;
                    $display("FAIL depth_dout0_c%0d got=%b/%h exp=1/%0d", c, o_dout0_valid, o_dout0_data, c);
                end
            end
            if (c == 3) begin
                n_tests++;
                if (o_dout0_valid !== 1'b0) begin n_fail++; $display("FAIL depth_dout0_empty got=%b exp=0", o_dout0_valid); end
            end
            if (c == 4 || c == 5) begin
                n_tests++;
                if (o_dout1_valid !== 1'b1 || o_dout1_data !== DATA_W'(c - 3)) begin
                    n_fail++;
                    $display("FAIL depth_dout1_c%0d got=%b/%h exp=1/%0d", c, o_dout1_valid, o_dout1_data, c - 3);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (o_dout0_valid !== 1'b1 || o_dout0_data !== 8'h03 || o_dout1_valid !== 1'b1 || o_dout1_data !== 8'h03) begin
                    n_fail++;
                    $display("FAIL depth_third_word got=%b/%h %b/%h exp=1/03 1/03",
                             o_dout0_valid, o_dout0_data, o_dout1_valid, o_dout1_data);
                end
            end
        end
        @(posedge clk);
        #1;
        i_din_valid = 1'b0;
        i_dout0_ready = 1'b0;
        i_dout1_ready = 1'b0;
    endtask

    task automatic test_alternate();
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(DATA_W'(i));
        run(2, 200);
        n_tests++;
        if (rx0.size() !== 8 || rx1.size() !== 8) begin
            n_fail++;
            $display("FAIL alt_count got=%0d/%0d exp=8/8", rx0.size(), rx1.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (rx0[i] !== DATA_W'(i) || rx1[i] !== DATA_W'(i)) begin
                    n_fail++;
                    $display("FAIL alt_word%0d got=%h/%h exp=%h", i, rx0[i], rx1[i], DATA_W'(i));
                end
            end
        end
        n_tests++;
        if (inv_viol !== 0) begin n_fail++; $display("FAIL alt_model got=%0d exp=0", inv_viol); end
    endtask

    task automatic test_random();
        tx.delete();
        for (int i = 0; i < 60; i++) tx.push_back(DATA_W'($urandom_range(255)));
        run(1, 3000);
        n_tests++;
        if (rx0.size() !== sent.size() || rx1.size() !== sent.size()) begin
            n_fail++;
            $display("FAIL rand_count got=%0d/%0d exp=%0d", rx0.size(), rx1.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                n_tests++;
                if (rx0[i] !== sent[i] || rx1[i] !== sent[i]) begin
                    n_fail++;
                    $display("FAIL rand_word%0d got=%h/%h exp=%h", i, rx0[i], rx1[i], sent[i]);
                end
            end
        end
        n_tests++;
        if (acc !== sent.size()) begin n_fail++; $display("FAIL rand_accepted got=%0d exp=%0d", acc, sent.size()); end
        n_tests++;
        if (inv_viol !== 0) begin n_fail++; $display("FAIL rand_model got=%0d exp=0", inv_viol); end
    endtask

    task automatic test_reset_mid();
        logic accepted = 1'b0;
        logic taken0 = 1'b0;
        i_dout0_ready = 1'b1;
        i_dout1_ready = 1'b0;
        for (int c = 0; c < 4 && !taken0; c++) begin
            @(posedge clk);
            #1;
            i_din_valid = !accepted;
            i_din_data = 8'h7E;
            @(negedge clk);
            if (i_din_valid && o_din_ready) accepted = 1'b1;
            if (o_dout0_valid && i_dout0_ready) taken0 = 1'b1;
        end
        n_tests++;
        if (taken0 !== 1'b1) begin n_fail++; $display("FAIL rmid_dout0_took got=%b exp=1", taken0); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_din_valid = !accepted;
        @(negedge clk);
        n_tests++;
        if (o_din_ready !== 1'b0 || o_dout0_valid !== 1'b0 || o_dout1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_during got=%b%b%b exp=000", o_din_ready, o_dout0_valid, o_dout1_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_din_valid = 1'b0;
        i_dout1_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_dout0_valid !== 1'b0 || o_dout1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_after got=%b%b exp=00", o_dout0_valid, o_dout1_valid);
        end
        @(posedge clk);
        #1;
        i_din_valid = 1'b1;
        i_din_data = 8'h7E;
        @(negedge clk);
        n_tests++;
        if (o_din_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_reassert_ready got=%b exp=1", o_din_ready); end
        if (LAT != 0) begin
            @(posedge clk);
            #1;
            i_din_valid = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (o_dout0_valid !== 1'b1 || o_dout0_data !== 8'h7E || o_dout1_valid !== 1'b1 || o_dout1_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL rmid_reassert_out got=%b/%h %b/%h exp=1/7e 1/7e",
                     o_dout0_valid, o_dout0_data, o_dout1_valid, o_dout1_data);
        end
        @(posedge clk);
        #1;
        i_din_valid = 1'b0;
        i_dout0_ready = 1'b0;
        i_dout1_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_broadcast();
`ifdef BCAST2_DECOUPLE_EN
        test_depth();
`else
        test_stall();
`endif
        test_alternate();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
